// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and constants for the pipeline stall controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;
    localparam int REG_W_DEF = 5;
    localparam int ZERO_REG  = 0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             i_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_hazard
);
    // Writes to the zero register never create a real dependency
    assign o_hazard = i_mem_read && (i_ex_rt != REG_W'(ZERO_REG)) &&
                      (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: pipeline register enables/flushes for load-use, branch and memory-wait stalls
// Optional STALL_COUNTER_EN adds a saturating count of PC-stalled cycles.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int MEM_TIMEOUT = 15
`ifdef STALL_COUNTER_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
`ifdef STALL_COUNTER_EN
    input  logic             ClrCount,
    output logic [CNT_W-1:0] StallCount,
`endif
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Access,
    input  logic             MEM_Ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MEM_Timeout,
    output logic [1:0]       State
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_timeout, w_timeout_next;
    logic          w_active, w_hazard;

    load_use_detect #(.REG_W(REG_W)) u_luse (
        .i_mem_read (IDEX_MemRead),
        .i_ex_rt    (IDEX_Rt),
        .i_id_rs    (IFID_Rs),
        .i_id_rt    (IFID_Rt),
        .o_hazard   (w_hazard)
    );

    // Next state, wait counter and whether the pipeline may advance this cycle
    always_comb begin
        w_next         = ST_RUN;
        w_cnt_next     = '0;
        w_timeout_next = r_timeout;
        w_active       = 1'b0;
        case (r_state)
            ST_FAULT: begin
                w_next     = ST_FAULT;
                w_cnt_next = r_cnt;
            end
            ST_MEMWAIT: begin
                if (MEM_Ready) begin
                    w_active = 1'b1;
                end else if (r_cnt == CW'(MEM_TIMEOUT)) begin
                    w_next         = ST_FAULT;
                    w_cnt_next     = r_cnt;
                    w_timeout_next = 1'b1;
                end else begin
                    w_next     = ST_MEMWAIT;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                if (MEM_Access && !MEM_Ready) begin
                    w_next     = ST_MEMWAIT;
                    w_cnt_next = CW'(1);
                end else begin
                    w_active = 1'b1;
                end
            end
        endcase
    end

    // A memory-wait exit cycle decodes exactly like RUN, so no bubble is lost
    assign {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush, IDEXFlush} =
        (Rst || !w_active) ? 7'b0000000 :
        EX_BranchTaken     ? 7'b1111111 :
        w_hazard           ? 7'b0011101 : 7'b1111100;

    assign MEM_Timeout = r_timeout;
    assign State       = r_state;

    // State, wait counter and sticky timeout flag
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] r_stall;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_stall <= '0;
        else if (ClrCount)
            r_stall <= '0;
        else if (!PCWrite && r_stall != '1)
            r_stall <= r_stall + 1'b1;
    end

    assign StallCount = r_stall;
`endif
endmodule
